// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory fetch bus.
// Ports: imem_req/imem_addr (fetch side), imem_ready/imem_rdata (memory side).
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage with PC, FETCH/WAIT/HOLD FSM, hold buffer, IF/ID reg.
// Ports: clk, reset (sync, active-low), stall, flush, PCSrc, BranchTarget,
//   JumpTarget, JrTarget; imem (instr_fetch_if.master); IF_ID_Instr,
//   IF_ID_PC4, IF_ID_Valid, OpCode, Funct.
// Option: define DELAY_SLOT_EN to keep the IF/ID entry across a flush.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [1:0]           PCSrc,
  input  logic [31:0]          BranchTarget,
  input  logic [31:0]          JumpTarget,
  input  logic [31:0]          JrTarget,
  instr_fetch_if.master        imem,
  output logic [31:0]          IF_ID_Instr,
  output logic [31:0]          IF_ID_PC4,
  output logic                 IF_ID_Valid,
  output logic [5:0]           OpCode,
  output logic [5:0]           Funct
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] wait_addr_q, wait_addr_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] cur_addr;
  logic [31:0] seq_pc4;
  logic [31:0] target;
  logic [31:0] redirect;
  logic        req;

  // Request drops combinationally under reset so a pending
  // transaction is abandoned without waiting for imem_ready.
  assign req      = reset && (state_q != S_HOLD);
  // While waiting, the issued address stays put even if a
  // redirect has already moved the PC on.
  assign cur_addr = (state_q == S_WAIT) ? wait_addr_q : pc_q;
  assign seq_pc4  = cur_addr + 32'd4;

  assign imem.imem_req  = req;
  assign imem.imem_addr = cur_addr;

  assign IF_ID_Instr = ifid_instr_q;
  assign IF_ID_PC4   = ifid_pc4_q;
  assign IF_ID_Valid = ifid_valid_q;
  assign OpCode      = ifid_instr_q[31:26];
  assign Funct       = ifid_instr_q[5:0];

  // PCSrc=00 on a flush resumes right after the IF/ID entry.
  always_comb begin
    target = ifid_pc4_q;
    unique case (PCSrc)
      2'b01:   target = BranchTarget;
      2'b10:   target = JumpTarget;
      2'b11:   target = JrTarget;
      default: target = ifid_pc4_q;
    endcase
    redirect = {target[31:2], 2'b00};
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wait_addr_d  = wait_addr_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (flush) begin
      pc_d         = redirect;
      hold_instr_d = '0;
      hold_pc4_d   = '0;
`ifdef DELAY_SLOT_EN
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
`else
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
`endif
      // An unfinished request must still see its handshake
      // through; its data is discarded via the kill flag.
      if (req && !imem.imem_ready) begin
        state_d     = S_WAIT;
        kill_d      = 1'b1;
        wait_addr_d = cur_addr;
      end else begin
        state_d = S_FETCH;
        kill_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_FETCH, S_WAIT: begin
          if (imem.imem_ready) begin
            state_d = S_FETCH;
            kill_d  = 1'b0;
            if (kill_q) begin
              if (!stall) ifid_valid_d = 1'b0;
            end else if (stall) begin
              hold_instr_d = imem.imem_rdata;
              hold_pc4_d   = seq_pc4;
              pc_d         = seq_pc4;
              state_d      = S_HOLD;
            end else begin
              ifid_instr_d = imem.imem_rdata;
              ifid_pc4_d   = seq_pc4;
              ifid_valid_d = 1'b1;
              pc_d         = seq_pc4;
            end
          end else begin
            state_d     = S_WAIT;
            wait_addr_d = cur_addr;
            if (!stall) ifid_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_instr_d = hold_instr_q;
            ifid_pc4_d   = hold_pc4_q;
            ifid_valid_d = 1'b1;
            state_d      = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      wait_addr_q  <= '0;
      kill_q       <= 1'b0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wait_addr_q  <= wait_addr_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a delivery scoreboard.
// Memory returns addr ^ TAG; expected deliveries are queued by address.
module tb_instr_fetch;
  localparam logic [31:0] TAG = 32'hA5C3_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] JrTarget;
  logic        ready;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  instr_fetch_if bus();
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = bus.imem_addr ^ TAG;

  instr_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .JrTarget     (JrTarget),
    .imem         (bus.master),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_PC4    (IF_ID_PC4),
    .IF_ID_Valid  (IF_ID_Valid),
    .OpCode       (OpCode),
    .Funct        (Funct)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; a fresh IF/ID load (no stall/flush/reset at the
  // edge, valid afterwards) is checked against the queue head.
  task automatic tick();
    logic        upd;
    logic [31:0] a;
    logic [31:0] w;
    @(posedge clk);
    upd = reset && !stall && !flush;
    #1;
    if (upd && IF_ID_Valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_empty observed=%h expected=none", IF_ID_Instr);
      end else begin
        a = exp_q.pop_front();
        w = a ^ TAG;
        chk("sb_instr", IF_ID_Instr, w);
        chk("sb_pc4", IF_ID_PC4, a + 32'd4);
        chk("sb_opcode", {26'b0, OpCode}, {26'b0, w[31:26]});
        chk("sb_funct", {26'b0, Funct}, {26'b0, w[5:0]});
      end
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; PCSrc = 2'b00;
    BranchTarget = '0; JumpTarget = '0; JrTarget = '0; ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, IF_ID_Valid}, 32'd0);
    chk("rst_instr", IF_ID_Instr, 32'd0);
    chk("rst_pc4", IF_ID_PC4, 32'd0);

    // sequential fetch
    reset = 1'b1; #1;
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("seq_addr", bus.imem_addr, 32'h0040_0000 + 32'(4 * i));
      exp_q.push_back(32'h0040_0000 + 32'(4 * i));
      tick();
      if (i == 0) chk("first_pc4", IF_ID_PC4, 32'h0040_0004);
    end

    // memory not ready for 3 cycles
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("wait_addr", bus.imem_addr, 32'h0040_0008);
      tick();
      chk("wait_bubble", {31'b0, IF_ID_Valid}, 32'd0);
    end
    ready = 1'b1; #1;
    chk("wait_addr4", bus.imem_addr, 32'h0040_0008);
    exp_q.push_back(32'h0040_0008);
    tick();

    // stall on completion -> HOLD
    stall = 1'b1;
    exp_q.push_back(32'h0040_000C);
    tick();
    chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
    chk("hold_pc4", IF_ID_PC4, 32'h0040_000C);
    tick();
    chk("hold_req2", {31'b0, bus.imem_req}, 32'd0);
    chk("hold_valid", {31'b0, IF_ID_Valid}, 32'd1);
    stall = 1'b0;
    tick();
    chk("hold_out_pc4", IF_ID_PC4, 32'h0040_0010);
    chk("after_hold_addr", bus.imem_addr, 32'h0040_0010);

    // flush during WAIT
    ready = 1'b0;
    tick();
    flush = 1'b1; PCSrc = 2'b01; BranchTarget = 32'h0040_0100;
    tick();
    flush = 1'b0; #1;
    chk("fw_addr_held", bus.imem_addr, 32'h0040_0010);
    chk("fw_valid", {31'b0, IF_ID_Valid}, 32'd0);
    chk("fw_instr", IF_ID_Instr, 32'd0);
    tick();
    chk("fw_addr_held2", bus.imem_addr, 32'h0040_0010);
    ready = 1'b1;
    tick();
    chk("fw_drop", {31'b0, IF_ID_Valid}, 32'd0);
    chk("fw_target", bus.imem_addr, 32'h0040_0100);
    exp_q.push_back(32'h0040_0100);
    tick();

    // flush and stall together, unaligned jr target
    flush = 1'b1; stall = 1'b1; PCSrc = 2'b11; JrTarget = 32'h0040_0203;
    tick();
    chk("fs_addr", bus.imem_addr, 32'h0040_0200);
    chk("fs_valid", {31'b0, IF_ID_Valid}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    exp_q.push_back(32'h0040_0200);
    tick();

    // second flush replaces the pending target
    ready = 1'b0;
    tick();
    flush = 1'b1; PCSrc = 2'b01; BranchTarget = 32'h0040_0100;
    tick();
    PCSrc = 2'b10; JumpTarget = 32'h0040_0300;
    tick();
    flush = 1'b0; #1;
    chk("ff_addr_held", bus.imem_addr, 32'h0040_0204);
    ready = 1'b1;
    tick();
    chk("ff_target", bus.imem_addr, 32'h0040_0300);
    exp_q.push_back(32'h0040_0300);
    tick();

    // PCSrc=00 flush from HOLD resumes after the IF/ID entry
    stall = 1'b1;
    tick();
    flush = 1'b1; PCSrc = 2'b00;
    tick();
    chk("seq_flush_addr", bus.imem_addr, 32'h0040_0304);
    flush = 1'b0; stall = 1'b0;
    exp_q.push_back(32'h0040_0304);
    tick();

    // reset during WAIT
    ready = 1'b0; stall = 1'b1;
    tick();
    chk("pre_rst_valid", {31'b0, IF_ID_Valid}, 32'd1);
    reset = 1'b0; #1;
    chk("rst_req_comb", {31'b0, bus.imem_req}, 32'd0);
    tick();
    chk("midrst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, IF_ID_Valid}, 32'd0);
    reset = 1'b1; stall = 1'b0; ready = 1'b1; #1;
    chk("restart_req", {31'b0, bus.imem_req}, 32'd1);
    chk("restart_addr", bus.imem_addr, 32'h0040_0000);
    exp_q.push_back(32'h0040_0000);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 at a rising clk edge resets the block).
REQ-004 stall  input  1  hazard-unit stall; holds PC and IF/ID register.
REQ-005 flush  input  1  redirect request from EX stage, qualified by PCSrc.
REQ-006 PCSrc  input  2  next-PC select: 00 PC+4, 01 BranchTarget, 10 JumpTarget, 11 JrTarget.
REQ-007 BranchTarget, JumpTarget, JrTarget  input  32 each  redirect addresses.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  fetch address, word-aligned.
REQ-010 imem_ready  input  1  memory accepts request and returns data in the same cycle.
REQ-011 imem_rdata  input  32  fetched instruction, valid when imem_req and imem_ready are both 1.
REQ-012 IF_ID_Instr  output  32  instruction presented to decode.
REQ-013 IF_ID_PC4  output  32  address of IF_ID_Instr plus 4.
REQ-014 IF_ID_Valid  output  1  IF_ID_Instr is a live instruction.
REQ-015 OpCode, Funct  output  6 each  IF_ID_Instr[31:26] and IF_ID_Instr[5:0], combinational, feeding Control.

Function
REQ-016 FSM states SHALL be FETCH (request issued), WAIT (request pending, no ready), HOLD (data captured during stall, no request).
REQ-017 imem_req SHALL be 1 in FETCH and WAIT and 0 in HOLD; imem_addr SHALL equal PC and SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-018 Transfer completes on any cycle with imem_req=1 and imem_ready=1; FETCH goes to WAIT when imem_ready=0.
REQ-019 Completion with stall=0: IF_ID_Instr<=imem_rdata, IF_ID_PC4<=PC+4, IF_ID_Valid<=1, PC<=PC+4, state FETCH; sustained throughput is one instruction per cycle.
REQ-020 Completion with stall=1: data and PC+4 go to a one-entry hold buffer, PC<=PC+4, state HOLD, IF/ID unchanged.
REQ-021 In HOLD with stall=0: the hold buffer loads into IF/ID with IF_ID_Valid<=1, and state returns to FETCH.
REQ-022 While stall=1 and flush=0, IF_ID_Instr, IF_ID_PC4 and IF_ID_Valid SHALL hold.
REQ-023 flush=1 SHALL override stall: PC<=target selected by PCSrc; the hold buffer is discarded; IF_ID_Instr<=0 and IF_ID_Valid<=0; state FETCH.
REQ-024 flush=1 with PCSrc=00 SHALL be treated as PC+4 of IF_ID_PC4, i.e. resume sequentially.
REQ-025 Flush while in WAIT: the kill flag is set, the address is held until imem_ready, the returned data is dropped, then the target is fetched; the new PC is latched immediately, so no further flush information is lost.
REQ-026 A second flush while the kill flag is set SHALL replace the pending target; only the latest target is fetched.
REQ-027 Target addresses SHALL be forced word-aligned (bits [1:0]=0); PC arithmetic wraps modulo 2^32.

Reset
REQ-028 On reset=0: PC=RESET_PC; state FETCH; IF_ID_Instr=0; IF_ID_PC4=0; IF_ID_Valid=0; the hold buffer and kill flag are cleared.
REQ-029 imem_req SHALL be 0 during any cycle with reset=0 and SHALL rise in the first cycle after reset is released.
REQ-030 Reset mid-transaction SHALL abandon the pending request without waiting for imem_ready.

Configuration
REQ-031 Macro DELAY_SLOT_EN: when defined, a flush SHALL keep the IF/ID entry (the delay-slot instruction) and stall-hold it per REQ-022, killing only in-flight or held fetches.
REQ-032 Without DELAY_SLOT_EN, a flush SHALL invalidate IF/ID per REQ-023.

Verification
REQ-033 Release reset with imem_ready=1 and memory returning addr-tagged words -> imem_addr sequence 0x00400000, 0x00400004, ...; IF_ID_PC4=0x00400004 one cycle after first request.
REQ-034 Hold imem_ready=0 for 3 cycles at 0x00400008 -> imem_addr stable for 4 cycles; IF_ID_Valid=0 bubble, then the instruction appears.
REQ-035 Assert stall for 2 cycles when a fetch completes -> state HOLD, imem_req=0, IF/ID unchanged; after stall drops, the held word appears with the correct PC4.
REQ-036 Apply flush with PCSrc=01, BranchTarget=0x00400100, during WAIT -> the returned word is dropped, and the next request is 0x00400100; IF_ID_Valid=0 without DELAY_SLOT_EN, and the entry is kept with it.
REQ-037 Assert flush and stall in the same cycle with PCSrc=11, JrTarget=0x00400203 -> redirect to 0x00400200; flush wins.
REQ-038 Drive reset=0 during WAIT -> next cycle imem_req=0 and IF_ID_Valid=0; refetch restarts at 0x00400000.
